// File: rtl/buffer_pkg.sv
// rtl/buffer_pkg.sv - shared defaults and width helpers for buffer blocks
package buffer_pkg;

    localparam int BUF_WIDTH = 8;
    localparam int BUF_DEPTH = 4;

    function automatic int buf_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // One extra bit so COUNT can represent DEPTH itself.
    function automatic int buf_cntw(input int depth);
        return buf_clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/buffer_elastic_mem.sv
// rtl/buffer_elastic_mem.sv - DEPTH x WIDTH register file, one write port, async read
module buffer_elastic_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/buffer_elastic.sv
// rtl/buffer_elastic.sv - elastic FIFO buffer with valid/ready on both sides
module buffer_elastic
    import buffer_pkg::*;
#(
    parameter int WIDTH    = BUF_WIDTH,
    parameter int DEPTH    = BUF_DEPTH,
    parameter int AFULL_TH = 3,
    localparam int CNTW    = buf_cntw(DEPTH)
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic [WIDTH-1:0] I,
    input  logic             I_VALID,
    output logic             I_READY,
    output logic [WIDTH-1:0] O,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic [CNTW-1:0]  COUNT,
    output logic             FULL,
    output logic             EMPTY,
    output logic             AFULL
);

    localparam int PTRW = buf_clog2(DEPTH);

    logic [PTRW-1:0]  r_wr_ptr;
    logic [PTRW-1:0]  r_rd_ptr;
    logic [CNTW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_rdata;

    // Every flag comes from r_count alone, so O_READY never reaches I_READY.
    assign FULL    = (r_count == CNTW'(DEPTH));
    assign EMPTY   = (r_count == '0);
    assign AFULL   = (r_count >= CNTW'(AFULL_TH));
    assign I_READY = !FULL;
    assign O_VALID = !EMPTY;
    assign COUNT   = r_count;

    assign w_push = I_VALID & I_READY;
    assign w_pop  = O_VALID & O_READY;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    buffer_elastic_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTRW)
    ) u_mem (
        .i_clk   (CLK),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (I),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // Unwritten or stale entries are hidden while the buffer is empty.
    assign O = O_VALID ? w_rdata : '0;

endmodule

// File: tb/tb_buffer_elastic.sv
// tb/tb_buffer_elastic.sv - self-checking bench for buffer_elastic
module tb_buffer_elastic;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 4;
    localparam int AFULL_TH = 3;
    localparam int CNTW     = 3;

    logic             CLK;
    logic             RSTB;
    logic [WIDTH-1:0] I;
    logic             I_VALID;
    logic             I_READY;
    logic [WIDTH-1:0] O;
    logic             O_VALID;
    logic             O_READY;
    logic [CNTW-1:0]  COUNT;
    logic             FULL;
    logic             EMPTY;
    logic             AFULL;

    int n_cmp;
    int n_fail;
    logic [WIDTH-1:0] mq[$];

    typedef struct {
        logic       iv;
        logic       ordy;
        logic [7:0] d;
        int         cnt;
        logic       ov;
        logic [7:0] o;
        logic       full;
        logic       afull;
        logic       irdy;
    } vec_t;

    vec_t vt[$];

    buffer_elastic #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .CLK     (CLK),
        .RSTB    (RSTB),
        .I       (I),
        .I_VALID (I_VALID),
        .I_READY (I_READY),
        .O       (O),
        .O_VALID (O_VALID),
        .O_READY (O_READY),
        .COUNT   (COUNT),
        .FULL    (FULL),
        .EMPTY   (EMPTY),
        .AFULL   (AFULL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference: a queue; acceptance decided from occupancy before the edge.
    task automatic tick();
        logic             p;
        logic             q;
        logic [WIDTH-1:0] d;
        p = I_VALID && (mq.size() < DEPTH);
        q = O_READY && (mq.size() > 0);
        d = I;
        @(posedge CLK);
        if (q) void'(mq.pop_front());
        if (p) mq.push_back(d);
        #1;
    endtask

    task automatic chk_model(string nm);
        int n;
        n = mq.size();
        chk({nm, ".count"}, 32'(COUNT), 32'(n));
        chk({nm, ".o_valid"}, 32'(O_VALID), 32'(n > 0));
        chk({nm, ".o"}, 32'(O), (n > 0) ? 32'(mq[0]) : 32'h0);
        chk({nm, ".full"}, 32'(FULL), 32'(n == DEPTH));
        chk({nm, ".empty"}, 32'(EMPTY), 32'(n == 0));
        chk({nm, ".afull"}, 32'(AFULL), 32'(n >= AFULL_TH));
        chk({nm, ".i_ready"}, 32'(I_READY), 32'(n < DEPTH));
    endtask

    task automatic add_vec(logic iv, logic ordy, logic [7:0] d, int cnt, logic ov,
                           logic [7:0] o, logic full, logic afull, logic irdy);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.d = d; v.cnt = cnt; v.ov = ov;
        v.o = o; v.full = full; v.afull = afull; v.irdy = irdy;
        vt.push_back(v);
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        RSTB    = 1'b1;
        I       = '0;
        I_VALID = 1'b0;
        O_READY = 1'b0;

        // Fill, refused fifth push, pop-while-full, drain, pop on empty.
        add_vec(1, 0, 8'hA0, 1, 1, 8'hA0, 0, 0, 1);
        add_vec(1, 0, 8'hA1, 2, 1, 8'hA0, 0, 0, 1);
        add_vec(1, 0, 8'hA2, 3, 1, 8'hA0, 0, 1, 1);
        add_vec(1, 0, 8'hA3, 4, 1, 8'hA0, 1, 1, 0);
        add_vec(1, 0, 8'hA4, 4, 1, 8'hA0, 1, 1, 0);
        add_vec(1, 1, 8'hB0, 3, 1, 8'hA1, 0, 1, 1);
        add_vec(1, 0, 8'hB0, 4, 1, 8'hA1, 1, 1, 0);
        add_vec(0, 1, 8'h00, 3, 1, 8'hA2, 0, 1, 1);
        add_vec(0, 1, 8'h00, 2, 1, 8'hA3, 0, 0, 1);
        add_vec(0, 1, 8'h00, 1, 1, 8'hB0, 0, 0, 1);
        add_vec(0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 1);
        add_vec(0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 1);

        #2 RSTB = 1'b0;
        #1;
        chk("rst.count", 32'(COUNT), 0);
        chk("rst.empty", 32'(EMPTY), 1);
        chk("rst.full", 32'(FULL), 0);
        chk("rst.afull", 32'(AFULL), 0);
        chk("rst.i_ready", 32'(I_READY), 1);
        chk("rst.o_valid", 32'(O_VALID), 0);
        chk("rst.o", 32'(O), 0);
        @(negedge CLK);
        RSTB = 1'b1;

        // Reset mid-stream, dropped between edges.
        I_VALID = 1'b1;
        I = 8'h11; tick();
        I = 8'h22; tick();
        I_VALID = 1'b0;
        chk("mid.count_pre", 32'(COUNT), 2);
        #2 RSTB = 1'b0;
        #1;
        mq.delete();
        chk("mid.count", 32'(COUNT), 0);
        chk("mid.empty", 32'(EMPTY), 1);
        chk("mid.o_valid", 32'(O_VALID), 0);
        chk("mid.o", 32'(O), 0);
        chk("mid.i_ready", 32'(I_READY), 1);
        #2 RSTB = 1'b1;
        I_VALID = 1'b1; I = 8'h33;
        tick();
        I_VALID = 1'b0;
        chk("mid.o_after", 32'(O), 32'h33);
        chk("mid.ov_after", 32'(O_VALID), 1);
        O_READY = 1'b1; tick(); O_READY = 1'b0;
        chk_model("mid.drain");

        for (int k = 0; k < vt.size(); k++) begin
            I_VALID = vt[k].iv; O_READY = vt[k].ordy; I = vt[k].d;
            tick();
            chk($sformatf("vec%0d.count", k), 32'(COUNT), 32'(vt[k].cnt));
            chk($sformatf("vec%0d.o_valid", k), 32'(O_VALID), 32'(vt[k].ov));
            chk($sformatf("vec%0d.o", k), 32'(O), 32'(vt[k].o));
            chk($sformatf("vec%0d.full", k), 32'(FULL), 32'(vt[k].full));
            chk($sformatf("vec%0d.afull", k), 32'(AFULL), 32'(vt[k].afull));
            chk($sformatf("vec%0d.i_ready", k), 32'(I_READY), 32'(vt[k].irdy));
        end

        // Streaming at COUNT=2 through the pointer wrap.
        O_READY = 1'b0; I_VALID = 1'b1;
        I = 8'hE0; tick();
        I = 8'hE1; tick();
        O_READY = 1'b1;
        for (int k = 0; k < 10; k++) begin
            I = 8'(k);
            tick();
            chk($sformatf("stream%0d.count", k), 32'(COUNT), 2);
            chk($sformatf("stream%0d.o", k), 32'(O), (k == 0) ? 32'hE1 : 32'(k - 1));
        end
        I_VALID = 1'b0;
        tick(); tick();
        chk_model("stream.end");

        // Push into empty while O_READY is held high.
        O_READY = 1'b1;
        chk("ffwt.ov_before", 32'(O_VALID), 0);
        I_VALID = 1'b1; I = 8'h5A;
        tick();
        I_VALID = 1'b0;
        chk("ffwt.ov_after", 32'(O_VALID), 1);
        chk("ffwt.o_after", 32'(O), 32'h5A);
        chk("ffwt.count", 32'(COUNT), 1);
        tick();
        chk("ffwt.popped", 32'(EMPTY), 1);

        for (int k = 0; k < 400; k++) begin
            I_VALID = 1'($urandom_range(0, 1));
            O_READY = ($urandom_range(0, 3) != 0) ? ((k / 40) % 2 == 0) : 1'($urandom_range(0, 1));
            I = 8'($urandom);
            tick();
            chk_model($sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
